// File: rtl/fp_sched_pkg.sv
// Shared types and constants for the FP issue scheduler.
//   fp_class_e : op class codes carried on req_class / iss_class / wb_sel
//   MAXLAT     : longest pipelined latency (FMA)
//   slot_t     : one reservation-table entry
//   class_lat  : pipelined latency of a class, 0 for DIV and unknown codes
package fp_sched_pkg;

  typedef enum logic [2:0] {
    CL_MISC = 3'd0,
    CL_ADD  = 3'd1,
    CL_MUL  = 3'd2,
    CL_FMA  = 3'd3,
    CL_DIV  = 3'd4
  } fp_class_e;

  localparam int MAXLAT = 5;
  localparam int TAG_W  = 5;
  localparam int HART_W = 1;

  // v reserves the result port for that cycle; live says whether the
  // result is still wanted (cleared by commit_kill, v stays set).
  typedef struct packed {
    logic              v;
    logic              live;
    logic [TAG_W-1:0]  rd;
    logic [HART_W-1:0] hart;
    logic [2:0]        cls;
  } slot_t;

  function automatic int class_lat(input logic [2:0] cls);
    case (cls)
      CL_MISC: return 1;
      CL_ADD:  return 3;
      CL_MUL:  return 4;
      CL_FMA:  return 5;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/fp_rr_arb.sv
// Round-robin arbiter.
//   clk, reset : clock, asynchronous active-low reset
//   eligible   : requesters allowed to win this cycle
//   grant      : one-hot winner (all zero when nothing is eligible)
// The search starts at the pointer; the pointer moves past the winner only
// when a grant is given.
module fp_rr_arb #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] eligible,
  output logic [NREQ-1:0] grant
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_n;
  int            idx;

  // Walk offsets from the far end down so the nearest eligible one wins.
  always_comb begin
    grant = '0;
    ptr_n = ptr_q;
    idx   = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % NREQ;
      if (eligible[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        ptr_n      = PW'((idx + 1) % NREQ);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else if (|grant) begin
      ptr_q <= ptr_n;
    end
  end

endmodule

// File: rtl/fp_issue_sched.sv
// FPU issue scheduler and result-port arbiter.
//   clk, reset            : clock, asynchronous active-low reset
//   req_valid/class/rd/hart : per-requester op offers (packed, requester r
//                           at slice r)
//   req_ready             : combinational one-hot grant
//   iss_valid/class/rd/hart : registered start to the fpu
//   div_valid / div_ack   : iterative divider result handshake
//   commit_kill           : multi-hot tag flush
//   wb_valid/rd/sel       : result-port writeback, driven from slot 0
//   wb_makes_rd           : wb_valid decoded per hart
// A shift-register reservation table books the result-port cycle of every
// pipelined op at grant time; the divider writes back only into free cycles.
module fp_issue_sched #(
  parameter int NREQ     = 2,
  parameter int NCOMMIT  = 32,
  parameter int LNCOMMIT = 5,
  parameter int NHART    = 1,
  parameter int LNHART   = 0,
  parameter int MAXLAT   = fp_sched_pkg::MAXLAT,
  localparam int HW      = (NHART == 1) ? 1 : LNHART
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [3*NREQ-1:0]      req_class,
  input  logic [LNCOMMIT*NREQ-1:0] req_rd,
  input  logic [HW*NREQ-1:0]     req_hart,
  output logic [NREQ-1:0]        req_ready,
  output logic                   iss_valid,
  output logic [2:0]             iss_class,
  output logic [LNCOMMIT-1:0]    iss_rd,
  output logic [HW-1:0]          iss_hart,
  input  logic                   div_valid,
  output logic                   div_ack,
  input  logic [NCOMMIT-1:0]     commit_kill,
  output logic                   wb_valid,
  output logic [LNCOMMIT-1:0]    wb_rd,
  output logic [2:0]             wb_sel,
  output logic [NHART-1:0]       wb_makes_rd
);

  import fp_sched_pkg::*;

  slot_t               slot_q [MAXLAT+2];
  slot_t               slot_n [MAXLAT+2];
  logic                div_busy_q;
  logic                div_live_q;
  logic [LNCOMMIT-1:0] div_rd_q;
  logic [HW-1:0]       div_hart_q;

  logic [NREQ-1:0]     eligible;
  logic [NREQ-1:0]     grant;
  logic [2:0]          sel_cls;
  logic [LNCOMMIT-1:0] sel_rd;
  logic [HW-1:0]       sel_hart;
  int                  sel_lat;
  logic                grant_pipe;
  logic                grant_div;

  function automatic logic is_killed(input logic [NCOMMIT-1:0] kill,
                                     input logic [LNCOMMIT-1:0] tag);
    return kill[tag];
  endfunction

  // A pipelined op of latency L lands in slot[L] at the edge, which is where
  // slot[L+1] shifts to, so that entry must be empty. Gated by reset so no
  // grant is shown while the block is held in reset.
  always_comb begin
    eligible = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (req_valid[r] && reset) begin
        if (req_class[3*r +: 3] == CL_DIV)
          eligible[r] = !div_busy_q;
        else if (class_lat(req_class[3*r +: 3]) != 0)
          eligible[r] = !slot_q[class_lat(req_class[3*r +: 3]) + 1].v;
      end
    end
  end

  fp_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk      (clk),
    .reset    (reset),
    .eligible (eligible),
    .grant    (grant)
  );

  assign req_ready = grant;

  always_comb begin
    sel_cls  = '0;
    sel_rd   = '0;
    sel_hart = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (grant[r]) begin
        sel_cls  = req_class[3*r +: 3];
        sel_rd   = req_rd[LNCOMMIT*r +: LNCOMMIT];
        sel_hart = req_hart[HW*r +: HW];
      end
    end
  end

  assign sel_lat    = class_lat(sel_cls);
  assign grant_div  = (|grant) && (sel_cls == CL_DIV);
  assign grant_pipe = (|grant) && !grant_div;

  // A dead divider result needs no port cycle, so it is acked regardless.
  assign div_ack = div_valid && div_busy_q && (!slot_q[1].v || !div_live_q);

  // Shift, kill, then drop in the new reservations. The divider writes
  // slot 0 and a grant writes slot L >= 1, so they never overlap.
  always_comb begin
    for (int k = 0; k < MAXLAT + 1; k++) begin
      slot_n[k]      = slot_q[k+1];
      slot_n[k].live = slot_q[k+1].live && !is_killed(commit_kill, slot_q[k+1].rd);
    end
    slot_n[MAXLAT+1] = '0;
    if (div_ack && div_live_q)
      slot_n[0] = '{v: 1'b1, live: !is_killed(commit_kill, div_rd_q),
                    rd: div_rd_q, hart: div_hart_q, cls: CL_DIV};
    if (grant_pipe) begin
      for (int k = 1; k <= MAXLAT; k++) begin
        if (k == sel_lat)
          slot_n[k] = '{v: 1'b1, live: !is_killed(commit_kill, sel_rd),
                        rd: sel_rd, hart: sel_hart, cls: sel_cls};
      end
    end
  end

  // Stage boundary: grant cycle -> issue register and reservation table.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < MAXLAT + 2; k++) slot_q[k] <= '0;
      iss_valid  <= 1'b0;
      iss_class  <= '0;
      iss_rd     <= '0;
      iss_hart   <= '0;
      div_busy_q <= 1'b0;
      div_live_q <= 1'b0;
      div_rd_q   <= '0;
      div_hart_q <= '0;
    end else begin
      for (int k = 0; k < MAXLAT + 2; k++) slot_q[k] <= slot_n[k];
      iss_valid <= |grant;
      if (|grant) begin
        iss_class <= sel_cls;
        iss_rd    <= sel_rd;
        iss_hart  <= sel_hart;
      end
      if (div_ack) begin
        div_busy_q <= 1'b0;
      end else if (grant_div) begin
        div_busy_q <= 1'b1;
        div_live_q <= !is_killed(commit_kill, sel_rd);
        div_rd_q   <= sel_rd;
        div_hart_q <= sel_hart;
      end else begin
        div_live_q <= div_live_q && !is_killed(commit_kill, div_rd_q);
      end
    end
  end

  // Stage boundary: slot 0 drives the result port.
  assign wb_valid = slot_q[0].v && slot_q[0].live;
  assign wb_rd    = slot_q[0].rd;
  assign wb_sel   = slot_q[0].cls;

  always_comb begin
    wb_makes_rd = '0;
    for (int h = 0; h < NHART; h++)
      wb_makes_rd[h] = wb_valid && (int'(slot_q[0].hart) == h);
  end

endmodule

// File: tb/tb_fp_issue_sched.sv
module tb_fp_issue_sched;
  localparam int NREQ = 2, NCOMMIT = 32, LNCOMMIT = 5, NHART = 1, LNHART = 0;
  localparam int HW = 1, MAXLAT = 5;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic [NREQ-1:0]          req_valid;
  logic [3*NREQ-1:0]        req_class;
  logic [LNCOMMIT*NREQ-1:0] req_rd;
  logic [HW*NREQ-1:0]       req_hart;
  logic [NREQ-1:0]          req_ready;
  logic                     iss_valid;
  logic [2:0]               iss_class;
  logic [LNCOMMIT-1:0]      iss_rd;
  logic [HW-1:0]            iss_hart;
  logic                     div_valid;
  logic                     div_ack;
  logic [NCOMMIT-1:0]       commit_kill;
  logic                     wb_valid;
  logic [LNCOMMIT-1:0]      wb_rd;
  logic [2:0]               wb_sel;
  logic [NHART-1:0]         wb_makes_rd;

  always #5 clk = ~clk;

  fp_issue_sched #(.NREQ(NREQ), .NCOMMIT(NCOMMIT), .LNCOMMIT(LNCOMMIT),
                   .NHART(NHART), .LNHART(LNHART), .MAXLAT(MAXLAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_class(req_class),
    .req_rd(req_rd), .req_hart(req_hart), .req_ready(req_ready),
    .iss_valid(iss_valid), .iss_class(iss_class), .iss_rd(iss_rd),
    .iss_hart(iss_hart), .div_valid(div_valid), .div_ack(div_ack),
    .commit_kill(commit_kill), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_sel(wb_sel), .wb_makes_rd(wb_makes_rd)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: a calendar of result-port cycles indexed by absolute
  // cycle number, plus divider state and the round-robin pointer.
  bit         cal_v    [64];
  bit         cal_live [64];
  logic [4:0] cal_rd   [64];
  logic [0:0] cal_hart [64];
  logic [2:0] cal_cls  [64];
  int         cyc;
  int         ptr;
  bit         div_busy, div_live;
  logic [4:0] div_rd;
  logic [0:0] div_hart;
  logic [NREQ-1:0] m_ready;
  int         m_g;
  bit         m_ack;
  bit         m_iss_valid;
  logic [2:0] m_iss_class;
  logic [4:0] m_iss_rd;
  logic [0:0] m_iss_hart;
  bit         m_wb_valid;
  logic [4:0] m_wb_rd;
  logic [2:0] m_wb_sel;

  function automatic int ref_lat(input logic [2:0] c);
    case (c)
      3'd0: return 1;
      3'd1: return 3;
      3'd2: return 4;
      3'd3: return 5;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      cal_v[i] = 0; cal_live[i] = 0; cal_rd[i] = '0; cal_hart[i] = '0; cal_cls[i] = '0;
    end
    cyc = 0; ptr = 0; div_busy = 0; div_live = 0; div_rd = '0; div_hart = '0;
    m_iss_valid = 0; m_iss_class = '0; m_iss_rd = '0; m_iss_hart = '0;
  endtask

  task automatic put(input int at, input logic [4:0] rd, input logic [0:0] h,
                     input logic [2:0] c);
    int s;
    s = at % 64;
    cal_v[s] = 1; cal_live[s] = 1; cal_rd[s] = rd; cal_hart[s] = h; cal_cls[s] = c;
  endtask

  task automatic model_eval();
    int r;
    logic [2:0] c;
    m_ready = '0;
    m_g = -1;
    if (reset) begin
      for (int i = 0; i < NREQ; i++) begin
        r = (ptr + i) % NREQ;
        c = req_class[3*r +: 3];
        if (m_g < 0 && req_valid[r]) begin
          if (c == 3'd4) begin
            if (!div_busy) m_g = r;
          end else if (ref_lat(c) > 0 && !cal_v[(cyc + 1 + ref_lat(c)) % 64]) begin
            m_g = r;
          end
        end
      end
    end
    if (m_g >= 0) m_ready[m_g] = 1'b1;
    m_ack = reset && div_valid && div_busy && (!cal_v[(cyc + 1) % 64] || !div_live);
    m_wb_valid = cal_v[cyc % 64] && cal_live[cyc % 64];
    m_wb_rd = cal_rd[cyc % 64];
    m_wb_sel = cal_cls[cyc % 64];
  endtask

  task automatic model_commit();
    int s;
    logic [2:0] c;
    if (!reset) return;
    s = cyc % 64;
    cal_v[s] = 0; cal_live[s] = 0;
    if (m_ack) begin
      if (div_live) put(cyc + 1, div_rd, div_hart, 3'd4);
      div_busy = 0;
    end
    if (m_g >= 0) begin
      c = req_class[3*m_g +: 3];
      m_iss_valid = 1; m_iss_class = c;
      m_iss_rd = req_rd[5*m_g +: 5]; m_iss_hart = req_hart[m_g];
      if (c == 3'd4) begin
        div_busy = 1; div_live = 1; div_rd = req_rd[5*m_g +: 5]; div_hart = req_hart[m_g];
      end else begin
        put(cyc + 1 + ref_lat(c), req_rd[5*m_g +: 5], req_hart[m_g], c);
      end
      ptr = (m_g + 1) % NREQ;
    end else begin
      m_iss_valid = 0;
    end
    // A kill reaches every result that lands after this cycle.
    for (int d = 1; d <= MAXLAT + 1; d++) begin
      s = (cyc + d) % 64;
      if (cal_v[s] && commit_kill[cal_rd[s]]) cal_live[s] = 0;
    end
    if (commit_kill[div_rd]) div_live = 0;
    cyc++;
  endtask

  task automatic tick();
    model_eval();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_class = '0; req_rd = '0; req_hart = '0;
    div_valid = 1'b0; commit_kill = '0;
  endtask

  task automatic drive_req(input int r, input logic [2:0] c, input logic [4:0] rd);
    req_valid[r] = 1'b1;
    req_class[3*r +: 3] = c;
    req_rd[5*r +: 5] = rd;
    req_hart[r] = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    req_valid = 2'b11; req_class = 6'b001_001; div_valid = 1'b1;
    #1;
    checks++;
    if (iss_valid !== 1'b0 || wb_valid !== 1'b0 || wb_makes_rd !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: iss_valid=%b wb_valid=%b wb_makes_rd=%b want 0", iss_valid, wb_valid, wb_makes_rd);
    end
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (req_ready !== 2'b00 || div_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_comb: req_ready=%b div_ack=%b want 00/0", req_ready, div_ack);
    end
    clear_inputs();
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (iss_valid !== 1'b0 || wb_valid !== 1'b0 || wb_rd !== 5'd0 || wb_sel !== 3'd0) begin
      errors++;
      $display("FAIL reset_release: iss_valid=%b wb_valid=%b wb_rd=%0d wb_sel=%0d want 0", iss_valid, wb_valid, wb_rd, wb_sel);
    end
    tick(); tick();
  endtask

  task automatic test_single_add();
    drive_req(0, 3'd1, 5'd7);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL add_grant: req_ready=%b want 01", req_ready);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (iss_valid !== 1'b1 || iss_class !== 3'd1 || iss_rd !== 5'd7) begin
      errors++;
      $display("FAIL add_issue: iss_valid=%b class=%0d rd=%0d want 1/1/7", iss_valid, iss_class, iss_rd);
    end
    for (int i = 2; i <= 3; i++) begin
      tick();
      checks++;
      if (wb_valid !== 1'b0) begin
        errors++; $display("FAIL add_early_wb: cycle +%0d wb_valid=%b want 0", i, wb_valid);
      end
    end
    tick();
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd7 || wb_sel !== 3'd1 || wb_makes_rd !== 1'b1) begin
      errors++;
      $display("FAIL add_wb: wb_valid=%b rd=%0d sel=%0d makes_rd=%b want 1/7/1/1", wb_valid, wb_rd, wb_sel, wb_makes_rd);
    end
    tick();
  endtask

  task automatic test_fma_misc();
    drive_req(0, 3'd3, 5'd2);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL fma_grant: req_ready=%b want 01", req_ready);
    end
    tick();
    clear_inputs();
    tick(); tick(); tick();
    drive_req(1, 3'd0, 5'd5);
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++; $display("FAIL misc_held: req_ready=%b want 00", req_ready);
    end
    tick();
    checks++;
    if (req_ready !== 2'b10) begin
      errors++; $display("FAIL misc_grant: req_ready=%b want 10", req_ready);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd2 || wb_sel !== 3'd3) begin
      errors++; $display("FAIL fma_wb: wb_valid=%b rd=%0d sel=%0d want 1/2/3", wb_valid, wb_rd, wb_sel);
    end
    tick();
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_sel !== 3'd0) begin
      errors++; $display("FAIL misc_wb: wb_valid=%b rd=%0d sel=%0d want 1/5/0", wb_valid, wb_rd, wb_sel);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] want_g;
    logic [4:0] want_rd;
    for (int i = 0; i < 10; i++) begin
      clear_inputs();
      if (i < 6) begin
        drive_req(0, 3'd1, 5'd8);
        drive_req(1, 3'd1, 5'd9);
      end
      #1;
      if (i < 6) begin
        want_g = (i % 2 == 0) ? 2'b01 : 2'b10;
        checks++;
        if (req_ready !== want_g) begin
          errors++; $display("FAIL b2b_grant: cycle %0d req_ready=%b want %b", i, req_ready, want_g);
        end
      end
      if (i >= 4) begin
        want_rd = (i % 2 == 0) ? 5'd8 : 5'd9;
        checks++;
        if (wb_valid !== 1'b1 || wb_rd !== want_rd) begin
          errors++; $display("FAIL b2b_wb: cycle %0d wb_valid=%b rd=%0d want 1/%0d", i, wb_valid, wb_rd, want_rd);
        end
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_div();
    drive_req(0, 3'd4, 5'd3);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL div_grant: req_ready=%b want 01", req_ready);
    end
    tick();
    clear_inputs();
    drive_req(0, 3'd4, 5'd4);
    drive_req(1, 3'd2, 5'd12);
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++; $display("FAIL div_mul_grant: req_ready=%b want 10", req_ready);
    end
    tick();
    req_valid[1] = 1'b0;
    for (int t = 2; t <= 6; t++) begin
      div_valid = (t >= 5);
      #1;
      checks++;
      if (req_ready !== 2'b00) begin
        errors++; $display("FAIL div2_blocked: cycle %0d req_ready=%b want 00", t, req_ready);
      end
      if (t == 5) begin
        checks++;
        if (div_ack !== 1'b0) begin
          errors++; $display("FAIL div_ack_wait: div_ack=%b want 0", div_ack);
        end
      end
      if (t == 6) begin
        checks++;
        if (div_ack !== 1'b1 || wb_valid !== 1'b1 || wb_rd !== 5'd12 || wb_sel !== 3'd2) begin
          errors++;
          $display("FAIL div_ack_go: div_ack=%b wb_valid=%b rd=%0d sel=%0d want 1/1/12/2", div_ack, wb_valid, wb_rd, wb_sel);
        end
      end
      tick();
    end
    div_valid = 1'b0;
    #1;
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd3 || wb_sel !== 3'd4 || req_ready !== 2'b01) begin
      errors++;
      $display("FAIL div_wb: wb_valid=%b rd=%0d sel=%0d ready=%b want 1/3/4/01", wb_valid, wb_rd, wb_sel, req_ready);
    end
    tick();
    clear_inputs();
    div_valid = 1'b1;
    #1;
    checks++;
    if (div_ack !== 1'b1) begin
      errors++; $display("FAIL div2_ack: div_ack=%b want 1", div_ack);
    end
    tick();
    div_valid = 1'b0;
    #1;
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd4 || wb_sel !== 3'd4) begin
      errors++; $display("FAIL div2_wb: wb_valid=%b rd=%0d sel=%0d want 1/4/4", wb_valid, wb_rd, wb_sel);
    end
    tick();
  endtask

  task automatic test_kill();
    clear_inputs();
    drive_req(0, 3'd2, 5'd9);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL kill_mul_grant: req_ready=%b want 01", req_ready);
    end
    tick();
    clear_inputs();
    tick();
    commit_kill = 32'h1 << 9;
    tick();
    commit_kill = '0;
    drive_req(1, 3'd0, 5'd6);
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++; $display("FAIL kill_slot_reserved: req_ready=%b want 00", req_ready);
    end
    tick();
    checks++;
    if (req_ready !== 2'b10) begin
      errors++; $display("FAIL kill_misc_grant: req_ready=%b want 10", req_ready);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (wb_valid !== 1'b0 || wb_makes_rd !== 1'b0) begin
      errors++; $display("FAIL kill_wb_squashed: wb_valid=%b makes_rd=%b want 0/0", wb_valid, wb_makes_rd);
    end
    tick();
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd6 || wb_sel !== 3'd0) begin
      errors++; $display("FAIL kill_misc_wb: wb_valid=%b rd=%0d sel=%0d want 1/6/0", wb_valid, wb_rd, wb_sel);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    drive_req(0, 3'd1, 5'd1); tick();
    clear_inputs();
    drive_req(1, 3'd2, 5'd2); tick();
    clear_inputs();
    drive_req(0, 3'd3, 5'd3); tick();
    drive_req(1, 3'd1, 5'd4);
    div_valid = 1'b1;
    reset = 1'b0;
    #1;
    checks++;
    if (iss_valid !== 1'b0 || iss_class !== 3'd0 || iss_rd !== 5'd0 || iss_hart !== 1'b0 ||
        wb_valid !== 1'b0 || wb_rd !== 5'd0 || wb_sel !== 3'd0 || wb_makes_rd !== 1'b0 ||
        req_ready !== 2'b00 || div_ack !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: iss=%b/%0d/%0d/%b wb=%b/%0d/%0d/%b ready=%b ack=%b want all 0",
               iss_valid, iss_class, iss_rd, iss_hart, wb_valid, wb_rd, wb_sel, wb_makes_rd, req_ready, div_ack);
    end
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    clear_inputs();
    reset = 1'b1;
    drive_req(0, 3'd1, 5'd11);
    drive_req(1, 3'd1, 5'd12);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL postreset_ptr: req_ready=%b want 01", req_ready);
    end
    tick();
    req_valid[0] = 1'b0;
    #1;
    checks++;
    if (iss_valid !== 1'b1 || iss_rd !== 5'd11 || req_ready !== 2'b10) begin
      errors++; $display("FAIL postreset_issue: iss_valid=%b rd=%0d ready=%b want 1/11/10", iss_valid, iss_rd, req_ready);
    end
    tick();
    clear_inputs();
    for (int t = 2; t <= 3; t++) begin
      #1;
      checks++;
      if (wb_valid !== 1'b0) begin
        errors++; $display("FAIL postreset_flushed: cycle %0d wb_valid=%b want 0", t, wb_valid);
      end
      tick();
    end
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd11) begin
      errors++; $display("FAIL postreset_wb0: wb_valid=%b rd=%0d want 1/11", wb_valid, wb_rd);
    end
    tick();
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd12) begin
      errors++; $display("FAIL postreset_wb1: wb_valid=%b rd=%0d want 1/12", wb_valid, wb_rd);
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      clear_inputs();
      for (int r = 0; r < NREQ; r++) begin
        if ($urandom_range(0, 1) == 1)
          drive_req(r, 3'($urandom_range(0, 4)), 5'($urandom_range(0, 7)));
      end
      div_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) commit_kill = 32'h1 << $urandom_range(0, 7);
      #1;
      model_eval();
      checks++;
      if (req_ready !== m_ready || div_ack !== m_ack) begin
        errors++;
        $display("FAIL rand_comb: cycle %0d ready=%b ack=%b want %b/%b", n, req_ready, div_ack, m_ready, m_ack);
      end
      checks++;
      if (iss_valid !== m_iss_valid ||
          (m_iss_valid && (iss_class !== m_iss_class || iss_rd !== m_iss_rd || iss_hart !== m_iss_hart))) begin
        errors++;
        $display("FAIL rand_issue: cycle %0d iss=%b/%0d/%0d want %b/%0d/%0d", n, iss_valid, iss_class, iss_rd,
                 m_iss_valid, m_iss_class, m_iss_rd);
      end
      checks++;
      if (wb_valid !== m_wb_valid || wb_makes_rd !== 1'(m_wb_valid) ||
          (m_wb_valid && (wb_rd !== m_wb_rd || wb_sel !== m_wb_sel))) begin
        errors++;
        $display("FAIL rand_wb: cycle %0d wb=%b/%0d/%0d makes=%b want %b/%0d/%0d", n, wb_valid, wb_rd, wb_sel,
                 wb_makes_rd, m_wb_valid, m_wb_rd, m_wb_sel);
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    test_reset();
    test_single_add();
    test_fma_misc();
    test_back_to_back();
    test_div();
    test_kill();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
